// File: rtl/dram_access_ctrl.sv
// Sequencer between the MEM stage and a word-wide synchronous-read data DRAM.
// One request at a time; sub-word stores are read-modify-write, loads are lane-extracted.
module dram_access_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_sext;
    logic        r_we;
    logic        r_err;
    logic [15:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_word_store;
    logic        w_rd_done;

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (size)
            2'd0:    return {{24{sext & b[7]}}, b};
            2'd1:    return {{16{sext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Only called for byte/half stores; the untouched lanes keep the DRAM contents.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wdata,
                                                input logic [1:0] lo, input logic [1:0] size);
        logic [31:0] m;
        m = word;
        if (size == 2'd0) m[{lo, 3'b000} +: 8] = wdata[7:0];
        else              m[{lo[1], 4'b0000} +: 16] = wdata;
        return m;
    endfunction

    assign w_accept     = (r_state == IDLE) & req_valid;
    assign w_misaligned = (req_size == 2'd3)
                        | ((req_size == 2'd1) & req_addr[0])
                        | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    assign w_word_store = req_we & (req_size == 2'd2);
    assign w_rd_done    = (r_state == RD_WAIT) & (r_cnt == 2'd1);

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misaligned)      w_state_next = RESP;
                    else if (w_word_store) w_state_next = WRITE;
                    else                   w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: if (w_rd_done) w_state_next = r_we ? WRITE : RESP;
            WRITE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr_lo   <= '0;
            r_size      <= '0;
            r_sext      <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr_lo  <= req_addr[1:0];
                r_size     <= req_size;
                r_sext     <= req_sext;
                r_we       <= req_we;
                r_err      <= w_misaligned;
                r_wdata    <= req_wdata[15:0];
                r_rdata    <= '0;
                r_mem_addr <= {req_addr[31:2], 2'b00};
                r_cnt      <= 2'(RD_LAT);
                if (w_word_store && !w_misaligned) r_mem_wdata <= req_wdata;
            end
            if (r_state == RD_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
                if (w_rd_done) begin
                    if (r_we) r_mem_wdata <= merge_store(mem_rdata, r_wdata, r_addr_lo, r_size);
                    else      r_rdata     <= extract_load(mem_rdata, r_addr_lo, r_size, r_sext);
                end
            end
        end
    end

    // Write and response strobes are masked during reset so an aborted request leaves no trace.
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP) & ~cpu_rst;
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = resp_valid ? r_rdata : 32'd0;
    assign stall      = req_valid & (r_state != RESP) & ~cpu_rst;
    assign mem_we     = (r_state == WRITE) & ~cpu_rst;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl: one instance at RD_LAT=1 and one at RD_LAT=3,
// each with its own DRAM model; sel picks which instance is observed.
module tb_dram_access_ctrl;

    logic cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    logic        cpu_rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        sel;

    logic        req_ready_1, resp_valid_1, resp_err_1, stall_1, mem_we_1;
    logic [31:0] resp_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        req_ready_3, resp_valid_3, resp_err_3, stall_3, mem_we_3;
    logic [31:0] resp_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

    dram_access_ctrl #(.RD_LAT(1)) u_dut1 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_1), .resp_rdata(resp_rdata_1),
        .resp_err(resp_err_1), .stall(stall_1), .mem_addr(mem_addr_1), .mem_we(mem_we_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    dram_access_ctrl #(.RD_LAT(3)) u_dut3 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .req_valid(req_valid), .req_ready(req_ready_3),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_3), .resp_rdata(resp_rdata_3),
        .resp_err(resp_err_3), .stall(stall_3), .mem_addr(mem_addr_3), .mem_we(mem_we_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
    );

    // DRAM models: latency 1 is a direct read, latency 3 adds two register stages.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;
    logic [31:0] p0, p1;

    always @(posedge cpu_clk) begin
        if (pl_en) begin
            mem1[pl_addr[7:2]] <= pl_data;
            mem3[pl_addr[7:2]] <= pl_data;
        end else begin
            if (mem_we_1) mem1[mem_addr_1[7:2]] <= mem_wdata_1;
            if (mem_we_3) mem3[mem_addr_3[7:2]] <= mem_wdata_3;
        end
    end
    always @(posedge cpu_clk) begin
        p0 <= mem3[mem_addr_3[7:2]];
        p1 <= p0;
    end
    assign mem_rdata_1 = mem1[mem_addr_1[7:2]];
    assign mem_rdata_3 = p1;

    logic        v_ready, v_resp_valid, v_resp_err, v_stall, v_mem_we;
    logic [31:0] v_resp_rdata, v_mem_addr, v_mem_wdata;
    assign v_ready      = sel ? req_ready_3  : req_ready_1;
    assign v_resp_valid = sel ? resp_valid_3 : resp_valid_1;
    assign v_resp_err   = sel ? resp_err_3   : resp_err_1;
    assign v_stall      = sel ? stall_3      : stall_1;
    assign v_mem_we     = sel ? mem_we_3     : mem_we_1;
    assign v_resp_rdata = sel ? resp_rdata_3 : resp_rdata_1;
    assign v_mem_addr   = sel ? mem_addr_3   : mem_addr_1;
    assign v_mem_wdata  = sel ? mem_wdata_3  : mem_wdata_1;

    typedef struct {
        logic        sel;
        logic        pl;
        logic [31:0] pl_data;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_we_k;
        logic [31:0] exp_mwdata;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic pl, input logic [31:0] pd,
                                input logic we, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                                input logic [31:0] rdata, input logic err, input int we_k,
                                input logic [31:0] mwdata);
        vec_t v;
        v.sel = s; v.pl = pl; v.pl_data = pd; v.we = we; v.size = size; v.sext = sext;
        v.addr = addr; v.wdata = wdata; v.exp_lat = lat; v.exp_rdata = rdata;
        v.exp_err = err; v.exp_we_k = we_k; v.exp_mwdata = mwdata;
        return v;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge cpu_clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge cpu_clk);
        pl_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1; req_valid = 1'b0;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    // Presents one request at an IDLE cycle (k=0) and follows it to its response.
    task automatic apply_req(input vec_t v, output int lat, output logic [31:0] rdata,
                             output logic err, output int we_cnt, output int we_k,
                             output logic [31:0] we_data, output logic [31:0] we_addr,
                             output logic [31:0] resp_maddr, output logic stall_ok,
                             output logic ready_ok);
        @(negedge cpu_clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_sext = v.sext;
        req_addr = v.addr; req_wdata = v.wdata;
        #1;
        ready_ok = v_ready; lat = -1; rdata = '0; err = 1'b0; we_cnt = 0; we_k = -1;
        we_data = '0; we_addr = '0; resp_maddr = '0; stall_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(negedge cpu_clk);
                #1;
            end
            if (v_mem_we) begin
                we_cnt++;
                if (we_k < 0) begin
                    we_k = k; we_data = v_mem_wdata; we_addr = v_mem_addr;
                end
            end
            if (v_resp_valid) begin
                lat = k; rdata = v_resp_rdata; err = v_resp_err; resp_maddr = v_mem_addr;
                if (v_stall) stall_ok = 1'b0;
                break;
            end
            if (!v_stall) stall_ok = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    vec_t vecs [21];

    initial begin
        int lat, we_cnt, we_k, n_resp;
        logic [31:0] rdata, we_data, we_addr, resp_maddr;
        logic err, stall_ok, ready_ok, no_resp;
        logic [31:0] sdata [4];

        vecs[0]  = mk(0, 1, 32'h8899AABB, 0, 2'd0, 1, 32'h12, 32'h0,        2, 32'hFFFFFF99, 0, -1, 0);
        vecs[1]  = mk(0, 0, 0,            1, 2'd1, 0, 32'h12, 32'h1234,     3, 32'h0,        0,  2, 32'h1234AABB);
        vecs[2]  = mk(0, 0, 0,            1, 2'd2, 0, 32'h20, 32'hDEADBEEF, 2, 32'h0,        0,  1, 32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 0,            0, 2'd2, 0, 32'h20, 32'h0,        2, 32'hDEADBEEF, 0, -1, 0);
        vecs[4]  = mk(0, 0, 0,            0, 2'd1, 0, 32'h13, 32'h0,        1, 32'h0,        1, -1, 0);
        vecs[5]  = mk(0, 0, 0,            1, 2'd2, 0, 32'h22, 32'hCAFEF00D, 1, 32'h0,        1, -1, 0);
        vecs[6]  = mk(0, 1, 32'h8899AABB, 0, 2'd0, 0, 32'h13, 32'h0,        2, 32'h00000088, 0, -1, 0);
        vecs[7]  = mk(0, 0, 0,            0, 2'd1, 1, 32'h10, 32'h0,        2, 32'hFFFFAABB, 0, -1, 0);
        vecs[8]  = mk(0, 0, 0,            0, 2'd1, 0, 32'h12, 32'h0,        2, 32'h00008899, 0, -1, 0);
        vecs[9]  = mk(0, 0, 0,            1, 2'd0, 0, 32'h10, 32'hABCDEF77, 3, 32'h0,        0,  2, 32'h8899AA77);
        vecs[10] = mk(0, 0, 0,            0, 2'd3, 0, 32'h00, 32'h0,        1, 32'h0,        1, -1, 0);
        vecs[11] = mk(0, 0, 0,            0, 2'd2, 1, 32'h10, 32'h0,        2, 32'h8899AA77, 0, -1, 0);
        vecs[12] = mk(0, 0, 0,            0, 2'd0, 1, 32'h11, 32'h0,        2, 32'hFFFFFFAA, 0, -1, 0);
        vecs[13] = mk(0, 1, 32'h0,        1, 2'd0, 1, 32'h11, 32'hFFFFFF5A, 3, 32'h0,        0,  2, 32'h00005A00);
        vecs[14] = mk(0, 0, 0,            0, 2'd1, 1, 32'h10, 32'h0,        2, 32'h00005A00, 0, -1, 0);
        vecs[15] = mk(1, 1, 32'h0,        1, 2'd0, 0, 32'h41, 32'h5A,       5, 32'h0,        0,  4, 32'h00005A00);
        vecs[16] = mk(1, 0, 0,            0, 2'd0, 1, 32'h41, 32'h0,        4, 32'h0000005A, 0, -1, 0);
        vecs[17] = mk(1, 1, 32'hF00D8001, 0, 2'd1, 1, 32'h42, 32'h0,        4, 32'hFFFFF00D, 0, -1, 0);
        vecs[18] = mk(1, 0, 0,            1, 2'd1, 0, 32'h40, 32'h0000BEEF, 5, 32'h0,        0,  4, 32'hF00DBEEF);
        vecs[19] = mk(1, 0, 0,            1, 2'd2, 0, 32'h44, 32'h11223344, 2, 32'h0,        0,  1, 32'h11223344);
        vecs[20] = mk(1, 0, 0,            0, 2'd2, 0, 32'h41, 32'h0,        1, 32'h0,        1, -1, 0);

        cpu_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0; sel = 1'b0;
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
        check("rst_ready",      32'(v_ready), 1);
        check("rst_resp_valid", 32'(v_resp_valid), 0);
        check("rst_resp_err",   32'(v_resp_err), 0);
        check("rst_stall",      32'(v_stall), 0);
        check("rst_mem_we",     32'(v_mem_we), 0);
        check("rst_resp_rdata", v_resp_rdata, 0);
        check("rst_mem_addr",   v_mem_addr, 0);
        check("rst_mem_wdata",  v_mem_wdata, 0);

        // Continuous load stream on the RD_LAT=1 instance: IDLE, RD_WAIT, RESP per request.
        for (int i = 0; i < 4; i++) begin
            sdata[i] = 32'h1111_1111 * (i + 1);
            preload(32'h30 + 4 * i, sdata[i]);
        end
        @(negedge cpu_clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h30;
        #1;
        n_resp = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(negedge cpu_clk);
                #1;
            end
            check($sformatf("stream_c%0d_ready_stall_resp", c),
                  {29'd0, v_ready, v_stall, v_resp_valid},
                  {29'd0, (c % 3) == 0, (c % 3) != 2, (c % 3) == 2});
            if (v_resp_valid) begin
                check($sformatf("stream_r%0d_rdata", n_resp), v_resp_rdata, sdata[n_resp % 4]);
                n_resp++;
            end
            if ((c % 3) == 1) begin
                req_addr = 32'hFFFF_FFFC; req_size = 2'd3;
            end else if ((c % 3) == 2) begin
                req_addr = 32'h30 + 4 * n_resp; req_size = 2'd2;
            end
        end
        req_valid = 1'b0;
        check("stream_resp_count", n_resp, 4);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].sel != sel) begin
                pulse_reset();
                sel = vecs[i].sel;
            end
            if (vecs[i].pl) preload({vecs[i].addr[31:2], 2'b00}, vecs[i].pl_data);
            apply_req(vecs[i], lat, rdata, err, we_cnt, we_k, we_data, we_addr, resp_maddr,
                      stall_ok, ready_ok);
            check($sformatf("v%0d_ready", i),    32'(ready_ok), 1);
            check($sformatf("v%0d_latency", i),  lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i),    rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i),      32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_stall", i),    32'(stall_ok), 1);
            check($sformatf("v%0d_mem_addr", i), resp_maddr, {vecs[i].addr[31:2], 2'b00});
            check($sformatf("v%0d_we_count", i), we_cnt, (vecs[i].exp_we_k >= 0) ? 1 : 0);
            if (vecs[i].exp_we_k >= 0) begin
                check($sformatf("v%0d_we_cycle", i), we_k, vecs[i].exp_we_k);
                check($sformatf("v%0d_we_data", i),  we_data, vecs[i].exp_mwdata);
                check($sformatf("v%0d_we_addr", i),  we_addr, {vecs[i].addr[31:2], 2'b00});
            end
        end

        // Reset raised during the WRITE cycle of a RD_LAT=3 byte store.
        preload(32'h40, 32'h0);
        @(negedge cpu_clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h5A;
        repeat (4) @(negedge cpu_clk);
        #1;
        check("rstw_we_before",    32'(v_mem_we), 1);
        check("rstw_wdata_before", v_mem_wdata, 32'h00005A00);
        cpu_rst = 1'b1;
        #1;
        check("rstw_we_gated", 32'(v_mem_we), 0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0; req_valid = 1'b0;
        #1;
        check("rstw_ready_after", 32'(v_ready), 1);
        check("rstw_stall_after", 32'(v_stall), 0);
        no_resp = ~v_resp_valid;
        for (int c = 0; c < 3; c++) begin
            @(negedge cpu_clk);
            #1;
            if (v_resp_valid) no_resp = 1'b0;
        end
        check("rstw_no_resp", 32'(no_resp), 1);
        check("rstw_mem_untouched", mem3[16], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Sequencing controller between the MEM pipeline stage and a synchronous-read, word-wide data DRAM.
- Accepts one load/store request at a time via valid/ready, holds the pipeline via `stall`, and returns load data or store completion.
- Byte/half stores are done as read-modify-write: read word, wait DRAM latency, merge, write.
- Loads are byte/half extracted and zero- or sign-extended; misaligned accesses are flagged and never touch memory.

Parameters:
- RD_LAT, 1, DRAM read latency in cycles from mem_addr change to valid mem_rdata; legal 1..3.

Ports:
- cpu_clk  in  1  clock, rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_sext  in  1  load sign-extend enable; ignored for word and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- resp_err  out  1  misaligned or reserved size, valid with resp_valid
- stall  out  1  pipeline hold
- mem_addr  out  32  word-aligned DRAM address
- mem_we  out  1  DRAM write enable
- mem_wdata  out  32  DRAM write word
- mem_rdata  in  32  DRAM read word

Behaviour:
- Clock and reset: single clock cpu_clk. cpu_rst is synchronous and active-high.
- Reset values: state IDLE; req_ready 1; resp_valid, resp_err, stall, mem_we 0; resp_rdata, mem_addr, mem_wdata 0.
- mem_we is additionally gated by ~cpu_rst combinationally.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE: req_ready=1. On req_valid (accept edge T), latch addr, size, sext, we, wdata, and set `mem_addr={req_addr[31:2],2'b00}`. Check alignment; misaligned means:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size 3
- Transitions out of IDLE:
  - misaligned -> RESP with err=1.
  - word store -> WRITE.
  - load or byte/half store -> RD_WAIT, with a wait counter loaded to RD_LAT.
- RD_WAIT: decrement the counter each cycle. When it reaches 0, mem_rdata is valid:
  - load: register the extracted result, go to RESP.
  - sub-word store: register the merged word, go to WRITE.
- Merge rule: the byte lane selected by addr[1:0] (half lane by addr[1]) is replaced with wdata's low byte/half. All other lanes come from mem_rdata.
- WRITE: mem_we=1 for exactly one cycle, with mem_wdata = merged word (word store: wdata unchanged). Then go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata:
  - byte: lane selected by addr[1:0], zero- or sign-extended per sext.
  - half: lane selected by addr[1], zero- or sign-extended per sext.
  - word: raw mem_rdata.
  - store or err: 0.
- stall = req_valid & (state != RESP) & ~(state==IDLE & misaligned-free path ever completing same cycle). In effect stall=1 from the accept cycle through the cycle before RESP, and 0 in RESP.
- Latencies (accept at T; resp_valid cycle):
  - word store: T+2, mem_we at T+1.
  - load: T+1+RD_LAT.
  - sub-word store: T+2+RD_LAT, mem_we at T+1+RD_LAT.
  - error: T+1.
- Back-to-back: the next request is accepted the cycle after RESP (IDLE). Requests presented in RESP are not accepted.
- Request inputs are sampled only at accept; later changes are ignored.
- mem_addr holds its value until the next accept.
- Reset mid-operation (any state): next state IDLE, outputs at reset values. A write pending in WRITE during the reset cycle is suppressed (mem_we=0). No resp_valid is issued for the aborted request.

Test Plan:
1. RD_LAT=1, DRAM word[0x10]=0x8899AABB; load byte sext, addr 0x12 -> resp_valid at T+2, resp_rdata=0xFFFFFF99, err=0.
2. Same word; store half 0x1234 at 0x12 -> mem_we once at T+2, mem_wdata=0x1234AABB, mem_addr=0x10, resp_valid at T+3.
3. Store word 0xDEADBEEF at 0x20 -> mem_we at T+1 with mem_wdata=0xDEADBEEF, resp_valid at T+2. Then an immediate load word at 0x20 (accepted at T+3) -> resp_rdata=0xDEADBEEF.
4. Load half at 0x13, and store word at 0x22 -> each: resp_valid at T+1, resp_err=1, mem_we never asserted, resp_rdata=0.
5. RD_LAT=3; store byte 0x5A at 0x41 over 0x00000000 -> mem_we at T+4, mem_wdata=0x00005A00. Raising cpu_rst during the WRITE cycle instead -> mem_we=0, state IDLE, req_ready=1 next cycle, no resp.
6. Hold req_valid=1 with a load stream -> req_ready high only in IDLE; stall deasserts exactly in RESP cycles; one response per accepted request.
